hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the ID-stage hazard check. Replaces per-stage write-address comparison with a per-register pending-write scoreboard.
- Sits beside the ID stage: the decoder supplies the source/destination use of the instruction in ID, writeback retires writes, and flush logic retires squashed writes.
- Adds configurable register count, multiple in-flight writes per register (WAW tracking), optional same-cycle writeback bypass, stall-length monitoring and an underflow error flag.

Parameters:
- NUM_REGS, 4, number of architectural registers (≥2).
- ADDR_W, $clog2(NUM_REGS), register address width.
- CNT_W, 2, pending-write counter width per register; MAXP = 2^CNT_W-1.
- WB_BYPASS, 1, 1 = a register being written back this cycle counts as available for read.
- STALL_CNT_W, 8, width of the consecutive-stall counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- id_valid  in  1  valid instruction in ID
- id_rs_used  in  1  instruction reads rs
- id_rs_addr  in  ADDR_W  rs address
- id_rt_used  in  1  instruction reads rt
- id_rt_addr  in  ADDR_W  rt address
- id_wr_en  in  1  instruction writes a register
- id_wr_addr  in  ADDR_W  destination address
- flush  in  1  ID instruction is squashed this cycle (not issued)
- wb_valid  in  1  register-file write retiring this cycle
- wb_addr  in  ADDR_W  retiring write address
- kill_valid  in  1  in-flight (post-ID) write squashed this cycle
- kill_addr  in  ADDR_W  squashed write address
- stall  out  1  hold PC/IF-ID, insert bubble into ID/EX
- busy  out  1  any pending counter nonzero
- stall_cycles  out  STALL_CNT_W  consecutive stall cycles, saturating
- err_underflow  out  1  sticky: retire/kill with zero pending

Behaviour:
- State: pend[NUM_REGS] of CNT_W bits; stall_cycles; err_underflow.
- Reset (reset_n=0 at posedge): all pend=0, stall_cycles=0, err_underflow=0. While reset_n=0, stall is forced to 0. busy is 0 after reset.
- avail(r) = (pend[r]==0) || (WB_BYPASS && wb_valid && wb_addr==r && pend[r]==1).
- stall (combinational, same cycle) = reset_n && id_valid && !flush && ((id_rs_used && !avail(rs)) || (id_rt_used && !avail(rt)) || (id_wr_en && pend[wr]==MAXP && !(wb_valid && wb_addr==wr))).
- Issue = id_valid && !flush && !stall. On issue with id_wr_en, pend[wr] increments at the next edge.
- Each edge, per register r: pend[r] += inc(r) − wbdec(r) − killdec(r). Each term is 0 or 1, and all three may hit the same r in one cycle; the result is the arithmetic net.
- Underflow: if a decrement would take pend[r] below 0, clamp to 0 and set err_underflow (held until reset). Example: wb and kill to the same r with pend=1 → pend=0, err set.
- Overflow is impossible by construction of the saturation stall.
- stall_cycles: +1 each cycle stall=1, saturating at 2^STALL_CNT_W−1; cleared to 0 in the first cycle stall=0.
- busy = OR over all pend[r]≠0, registered view: it reflects the counters after the edge.
- Latency: an issued write is visible to the next cycle's ID check. A retire is visible in the same cycle only via bypass; otherwise it is visible next cycle.
- Reads of an unused operand (used=0) never stall, whatever its address.
- Reset mid-operation clears all pending state. Retires arriving after the reset are treated as underflow only if reset_n=1.

Test Plan:
- Reset, then id_valid, rs=1, rs_used, no pending → stall=0, busy=0, stall_cycles=0.
- Issue write r2. Next cycle, read rs=2 → stall=1. Assert wb_valid wb_addr=2 with WB_BYPASS=1 → stall=0 that cycle and pend[2]=0 after the edge. With WB_BYPASS=0 → stall=1, clearing one cycle later.
- CNT_W=2: issue 3 writes to r3, then a 4th write to r3 → stall=1. wb r3 the same cycle → stall=0 and pend[3] stays 3.
- Hold a dependent read 300 cycles with no wb → stall_cycles saturates at 255. Release with wb → stall_cycles=0 next cycle.
- pend[1]=1, wb_valid and kill_valid both on r1 → pend[1]=0, err_underflow=1 and sticky until reset_n=0.
- Issue and wb to the same register in one cycle, with pend=1 before → pend stays 1. flush=1 with id_wr_en → no increment, stall=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard for the ID stage: stalls reads of registers
// with outstanding writes and stalls new writes when a register's pending counter is full.
module hazard_scoreboard #(
  parameter int NUM_REGS    = 4,
  parameter int ADDR_W      = $clog2(NUM_REGS),
  parameter int CNT_W       = 2,
  parameter bit WB_BYPASS   = 1'b1,
  parameter int STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   id_valid,
  input  logic                   id_rs_used,
  input  logic [ADDR_W-1:0]      id_rs_addr,
  input  logic                   id_rt_used,
  input  logic [ADDR_W-1:0]      id_rt_addr,
  input  logic                   id_wr_en,
  input  logic [ADDR_W-1:0]      id_wr_addr,
  input  logic                   flush,
  input  logic                   wb_valid,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic                   kill_valid,
  input  logic [ADDR_W-1:0]      kill_addr,
  output logic                   stall,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   err_underflow
);

  localparam logic [CNT_W-1:0]       MAXP   = '1;
  localparam logic [CNT_W-1:0]       ONE    = CNT_W'(1);
  localparam logic [STALL_CNT_W-1:0] SC_MAX = '1;

  logic [CNT_W-1:0]    pend      [NUM_REGS];
  logic [CNT_W-1:0]    pend_next [NUM_REGS];
  logic [CNT_W:0]      up        [NUM_REGS];
  logic [1:0]          dn        [NUM_REGS];
  logic [NUM_REGS-1:0] wb_hit, kill_hit, wr_hit, avail, nonzero;
  logic                rs_block, rt_block, wr_block, issue, uf_next;

  // A register is readable when nothing is pending, or when its last pending
  // write is retiring right now and the bypass path is enabled.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      wb_hit[r]   = wb_valid && (wb_addr == ADDR_W'(r));
      kill_hit[r] = kill_valid && (kill_addr == ADDR_W'(r));
      nonzero[r]  = (pend[r] != '0);
      avail[r]    = !nonzero[r] || (WB_BYPASS && wb_hit[r] && (pend[r] == ONE));
    end
  end

  always_comb begin
    rs_block = id_rs_used && !avail[id_rs_addr];
    rt_block = id_rt_used && !avail[id_rt_addr];
    // A full counter only accepts a new write if a retire frees a slot this cycle.
    wr_block = id_wr_en && (pend[id_wr_addr] == MAXP) && !wb_hit[id_wr_addr];
    stall    = reset_n && id_valid && !flush && (rs_block || rt_block || wr_block);
    issue    = id_valid && !flush && !stall;
  end

  always_comb begin
    uf_next = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_hit[r] = issue && id_wr_en && (id_wr_addr == ADDR_W'(r));
      up[r]     = {1'b0, pend[r]} + (CNT_W+1)'(wr_hit[r]);
      dn[r]     = 2'(wb_hit[r]) + 2'(kill_hit[r]);
      if ((CNT_W+1)'(dn[r]) > up[r]) begin
        pend_next[r] = '0;
        uf_next      = 1'b1;
      end else begin
        pend_next[r] = CNT_W'(up[r] - (CNT_W+1)'(dn[r]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) pend[r] <= '0;
      stall_cycles  <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) pend[r] <= pend_next[r];
      err_underflow <= err_underflow | uf_next;
      if (stall) stall_cycles <= (stall_cycles == SC_MAX) ? stall_cycles : stall_cycles + 1'b1;
      else       stall_cycles <= '0;
    end
  end

  assign busy = |nonzero;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (bypass off/on) driven in parallel,
// directed scenarios plus random traffic against a per-register counter model.
module tb_hazard_scoreboard;
  localparam int NR = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic id_valid, id_rs_used, id_rt_used, id_wr_en, flush, wb_valid, kill_valid;
  logic [AW-1:0] id_rs_addr, id_rt_addr, id_wr_addr, wb_addr, kill_addr;
  logic stall0, busy0, err0, stall1, busy1, err1;
  logic [7:0] sc0, sc1;

  int n_checks = 0;
  int n_err = 0;
  int m_pend[2][NR];
  int m_sc[2];
  bit m_err[2];

  always #5 clk = ~clk;

  hazard_scoreboard #(.NUM_REGS(NR), .CNT_W(2), .WB_BYPASS(1'b0), .STALL_CNT_W(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs_used(id_rs_used), .id_rs_addr(id_rs_addr), .id_rt_used(id_rt_used), .id_rt_addr(id_rt_addr),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .kill_valid(kill_valid), .kill_addr(kill_addr),
    .stall(stall0), .busy(busy0), .stall_cycles(sc0), .err_underflow(err0));

  hazard_scoreboard #(.NUM_REGS(NR), .CNT_W(2), .WB_BYPASS(1'b1), .STALL_CNT_W(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs_used(id_rs_used), .id_rs_addr(id_rs_addr), .id_rt_used(id_rt_used), .id_rt_addr(id_rt_addr),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .kill_valid(kill_valid), .kill_addr(kill_addr),
    .stall(stall1), .busy(busy1), .stall_cycles(sc1), .err_underflow(err1));

  // Reference model: instance k has bypass == k.
  function automatic bit m_avail(int k, int r);
    int p = m_pend[k][r];
    return (p == 0) || (k == 1 && wb_valid && int'(wb_addr) == r && p == 1);
  endfunction

  function automatic bit m_stall(int k);
    if (!reset_n || !id_valid || flush) return 1'b0;
    if (id_rs_used && !m_avail(k, int'(id_rs_addr))) return 1'b1;
    if (id_rt_used && !m_avail(k, int'(id_rt_addr))) return 1'b1;
    if (id_wr_en && m_pend[k][id_wr_addr] == 3 && !(wb_valid && wb_addr == id_wr_addr)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy(int k);
    for (int r = 0; r < NR; r++) if (m_pend[k][r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    bit st[2];
    int v;
    for (int k = 0; k < 2; k++) st[k] = m_stall(k);
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        for (int r = 0; r < NR; r++) m_pend[k][r] = 0;
        m_sc[k] = 0;
        m_err[k] = 1'b0;
      end else begin
        for (int r = 0; r < NR; r++) begin
          v = m_pend[k][r];
          if (id_valid && !flush && !st[k] && id_wr_en && int'(id_wr_addr) == r) v = v + 1;
          if (wb_valid && int'(wb_addr) == r) v = v - 1;
          if (kill_valid && int'(kill_addr) == r) v = v - 1;
          if (v < 0) begin
            v = 0;
            m_err[k] = 1'b1;
          end
          m_pend[k][r] = v;
        end
        m_sc[k] = st[k] ? ((m_sc[k] == 255) ? 255 : m_sc[k] + 1) : 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs_used = 0; id_rt_used = 0; id_wr_en = 0; flush = 0;
    wb_valid = 0; kill_valid = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_wr_addr = 0; wb_addr = 0; kill_addr = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    id_valid = 1; id_rs_used = 1; id_rs_addr = 1;
    #1;
    n_checks++; if (stall1 !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall1); end
    n_checks++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy1); end
    n_checks++; if (sc1 !== 8'd0) begin n_err++; $display("FAIL reset_sc: got %0d want 0", sc1); end
    n_checks++; if (err1 !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err1); end
    id_rs_used = 0; id_wr_en = 1; id_wr_addr = 1;
    tick();
    n_checks++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL issue_busy: got %b want 1", busy1); end
    reset_n = 0; id_wr_en = 0; id_rs_used = 1; id_rs_addr = 1;
    #1;
    n_checks++; if (stall1 !== 1'b0) begin n_err++; $display("FAIL stall_in_reset: got %b want 0", stall1); end
    tick();
    reset_n = 1;
    idle();
    #1;
    n_checks++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL busy_after_reset: got %b want 0", busy1); end
  endtask

  task automatic test_bypass();
    do_reset();
    id_valid = 1; id_wr_en = 1; id_wr_addr = 2;
    tick();
    id_wr_en = 0; id_rs_used = 1; id_rs_addr = 2;
    #1;
    n_checks++; if (stall1 !== 1'b1) begin n_err++; $display("FAIL raw_stall_b1: got %b want 1", stall1); end
    n_checks++; if (stall0 !== 1'b1) begin n_err++; $display("FAIL raw_stall_b0: got %b want 1", stall0); end
    tick();
    wb_valid = 1; wb_addr = 2;
    #1;
    n_checks++; if (stall1 !== 1'b0) begin n_err++; $display("FAIL bypass_b1: got %b want 0", stall1); end
    n_checks++; if (stall0 !== 1'b1) begin n_err++; $display("FAIL nobypass_b0: got %b want 1", stall0); end
    tick();
    wb_valid = 0;
    #1;
    n_checks++; if (stall0 !== 1'b0) begin n_err++; $display("FAIL release_b0: got %b want 0", stall0); end
    n_checks++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL pend2_clear_b1: got %b want 0", busy1); end
    n_checks++; if (sc1 !== 8'd0) begin n_err++; $display("FAIL sc_b1: got %0d want 0", sc1); end
    n_checks++; if (sc0 !== 8'd2) begin n_err++; $display("FAIL sc_b0: got %0d want 2", sc0); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    id_valid = 1; id_wr_en = 1; id_wr_addr = 3;
    tick(); tick(); tick();
    #1;
    n_checks++; if (stall1 !== 1'b1) begin n_err++; $display("FAIL full_stall_b1: got %b want 1", stall1); end
    n_checks++; if (stall0 !== 1'b1) begin n_err++; $display("FAIL full_stall_b0: got %b want 1", stall0); end
    wb_valid = 1; wb_addr = 3;
    #1;
    n_checks++; if (stall1 !== 1'b0) begin n_err++; $display("FAIL full_wb_b1: got %b want 0", stall1); end
    n_checks++; if (stall0 !== 1'b0) begin n_err++; $display("FAIL full_wb_b0: got %b want 0", stall0); end
    tick();
    wb_valid = 0;
    #1;
    n_checks++; if (stall1 !== 1'b1) begin n_err++; $display("FAIL still_full: got %b want 1", stall1); end
    id_wr_en = 0; id_rs_used = 1; id_rs_addr = 3; wb_valid = 1; wb_addr = 3;
    #1;
    n_checks++; if (stall1 !== 1'b1) begin n_err++; $display("FAIL bypass_needs_one: got %b want 1", stall1); end
    idle();
    tick();
  endtask

  task automatic test_stall_sat();
    do_reset();
    id_valid = 1; id_wr_en = 1; id_wr_addr = 1;
    tick();
    id_wr_en = 0; id_rs_used = 1; id_rs_addr = 1;
    for (int i = 0; i < 300; i++) tick();
    n_checks++; if (sc1 !== 8'd255) begin n_err++; $display("FAIL sc_sat_b1: got %0d want 255", sc1); end
    n_checks++; if (sc0 !== 8'd255) begin n_err++; $display("FAIL sc_sat_b0: got %0d want 255", sc0); end
    wb_valid = 1; wb_addr = 1;
    tick();
    wb_valid = 0;
    #1;
    n_checks++; if (sc1 !== 8'd0) begin n_err++; $display("FAIL sc_clear_b1: got %0d want 0", sc1); end
    n_checks++; if (sc0 !== 8'd255) begin n_err++; $display("FAIL sc_hold_b0: got %0d want 255", sc0); end
    n_checks++; if (stall0 !== 1'b0) begin n_err++; $display("FAIL late_release_b0: got %b want 0", stall0); end
    tick();
    n_checks++; if (sc0 !== 8'd0) begin n_err++; $display("FAIL sc_clear_b0: got %0d want 0", sc0); end
  endtask

  task automatic test_underflow();
    do_reset();
    id_valid = 1; id_wr_en = 1; id_wr_addr = 1;
    tick();
    idle();
    wb_valid = 1; wb_addr = 1; kill_valid = 1; kill_addr = 1;
    tick();
    idle();
    n_checks++; if (err1 !== 1'b1) begin n_err++; $display("FAIL underflow_set: got %b want 1", err1); end
    n_checks++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL underflow_clamp: got %b want 0", busy1); end
    tick(); tick();
    n_checks++; if (err0 !== 1'b1) begin n_err++; $display("FAIL underflow_sticky: got %b want 1", err0); end
    reset_n = 0; wb_valid = 1; wb_addr = 1;
    tick();
    n_checks++; if (err1 !== 1'b0) begin n_err++; $display("FAIL err_reset: got %b want 0", err1); end
    reset_n = 1;
    tick();
    idle();
    n_checks++; if (err1 !== 1'b1) begin n_err++; $display("FAIL wb_after_reset: got %b want 1", err1); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    id_valid = 1; id_wr_en = 1; id_wr_addr = 0;
    tick();
    wb_valid = 1; wb_addr = 0;
    #1;
    n_checks++; if (stall1 !== 1'b0) begin n_err++; $display("FAIL issue_with_wb: got %b want 0", stall1); end
    tick();
    idle();
    id_valid = 1; id_rs_used = 1; id_rs_addr = 0;
    #1;
    n_checks++; if (stall0 !== 1'b1) begin n_err++; $display("FAIL pend_kept: got %b want 1", stall0); end
    wb_valid = 1; wb_addr = 0;
    #1;
    n_checks++; if (stall1 !== 1'b0) begin n_err++; $display("FAIL pend_is_one: got %b want 0", stall1); end
    wb_valid = 0; flush = 1; id_wr_en = 1; id_wr_addr = 2;
    #1;
    n_checks++; if (stall0 !== 1'b0) begin n_err++; $display("FAIL flush_no_stall: got %b want 0", stall0); end
    tick();
    flush = 0; id_wr_en = 0; id_rs_addr = 2; id_rt_used = 0; id_rt_addr = 0;
    #1;
    n_checks++; if (stall0 !== 1'b0) begin n_err++; $display("FAIL flush_no_inc: got %b want 0", stall0); end
    id_rs_used = 0; id_rs_addr = 0;
    #1;
    n_checks++; if (stall1 !== 1'b0) begin n_err++; $display("FAIL unused_operand: got %b want 0", stall1); end
    idle();
    tick();
  endtask

  task automatic test_random();
    bit es;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset_n    = ($urandom_range(0, 59) != 0);
      id_valid   = $urandom_range(0, 3) != 0;
      id_rs_used = $urandom_range(0, 1);
      id_rt_used = $urandom_range(0, 1);
      id_wr_en   = $urandom_range(0, 1);
      flush      = ($urandom_range(0, 9) == 0);
      wb_valid   = ($urandom_range(0, 2) == 0);
      kill_valid = ($urandom_range(0, 11) == 0);
      id_rs_addr = AW'($urandom_range(0, NR-1));
      id_rt_addr = AW'($urandom_range(0, NR-1));
      id_wr_addr = AW'($urandom_range(0, NR-1));
      wb_addr    = AW'($urandom_range(0, NR-1));
      kill_addr  = AW'($urandom_range(0, NR-1));
      #1;
      es = m_stall(0);
      n_checks++; if (stall0 !== es) begin n_err++; $display("FAIL rnd_stall_b0 cyc %0d: got %b want %b", i, stall0, es); end
      es = m_stall(1);
      n_checks++; if (stall1 !== es) begin n_err++; $display("FAIL rnd_stall_b1 cyc %0d: got %b want %b", i, stall1, es); end
      n_checks++; if (busy0 !== m_busy(0)) begin n_err++; $display("FAIL rnd_busy_b0 cyc %0d: got %b want %b", i, busy0, m_busy(0)); end
      n_checks++; if (busy1 !== m_busy(1)) begin n_err++; $display("FAIL rnd_busy_b1 cyc %0d: got %b want %b", i, busy1, m_busy(1)); end
      n_checks++; if (int'(sc0) != m_sc[0]) begin n_err++; $display("FAIL rnd_sc_b0 cyc %0d: got %0d want %0d", i, sc0, m_sc[0]); end
      n_checks++; if (int'(sc1) != m_sc[1]) begin n_err++; $display("FAIL rnd_sc_b1 cyc %0d: got %0d want %0d", i, sc1, m_sc[1]); end
      n_checks++; if (err0 !== m_err[0]) begin n_err++; $display("FAIL rnd_err_b0 cyc %0d: got %b want %b", i, err0, m_err[0]); end
      n_checks++; if (err1 !== m_err[1]) begin n_err++; $display("FAIL rnd_err_b1 cyc %0d: got %b want %b", i, err1, m_err[1]); end
      tick();
    end
    reset_n = 1;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_bypass();
    test_saturation();
    test_stall_sat();
    test_underflow();
    test_same_cycle();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
